// File: rtl/usr_regwr_evq.sv
// usr_regwr_evq: filters register-slave write strobes into a FWFT event FIFO with overflow accounting and run-gate flush
module usr_regwr_evq #(
  parameter int          DEPTH    = 16,
  parameter int          AW       = $clog2(DEPTH),
  parameter logic [3:0]  BS_ADDRH = 4'h0,
  parameter logic [13:0] WIN_LO   = 14'd2,
  parameter logic [13:0] WIN_HI   = 14'd511
) (
  input  logic          usr_clk,
  input  logic          usr_rst,
  input  logic          usr_regrw_run_i,
  input  logic          wr_en_i,
  input  logic [19:0]   wr_addr_i,
  input  logic [31:0]   wr_data_i,
  output logic          evt_valid_o,
  input  logic          evt_ready_i,
  output logic [13:0]   evt_addr_o,
  output logic [31:0]   evt_data_o,
  output logic [AW:0]   evq_level_o,
  output logic          evq_full_o,
  output logic [15:0]   ovf_cnt_o,
  output logic          ovf_sticky_o,
  input  logic          clr_i
);
  logic [45:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        run_d1, hit, pop, push, drop, run_fall;
  logic [13:0] widx;
  always_comb begin
    widx        = wr_addr_i[15:2];
    run_fall    = ~usr_regrw_run_i & run_d1;
    hit         = wr_en_i & (wr_addr_i[19:16] == BS_ADDRH) & (widx >= WIN_LO) & (widx <= WIN_HI);
    evq_level_o = wr_ptr - rd_ptr;
    evq_full_o  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    evt_valid_o = wr_ptr != rd_ptr;
    pop         = evt_valid_o & evt_ready_i;
    // a hit coinciding with a flush is discarded outright, never counted as a drop
    push        = hit & ~run_fall & (~evq_full_o | pop);
    drop        = hit & ~run_fall & evq_full_o & ~pop;
    {evt_addr_o, evt_data_o} = mem[rd_ptr[AW-1:0]];
  end
  always_ff @(posedge usr_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {widx, wr_data_i};
  end
  always_ff @(posedge usr_clk) begin
    if (usr_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      run_d1       <= 1'b0;
      ovf_cnt_o    <= '0;
      ovf_sticky_o <= 1'b0;
    end else begin
      run_d1 <= usr_regrw_run_i;
      if (run_fall) rd_ptr <= wr_ptr;
      else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
      if (clr_i) begin
        ovf_cnt_o    <= '0;
        ovf_sticky_o <= 1'b0;
      end else if (drop) begin
        ovf_cnt_o    <= (ovf_cnt_o == 16'hFFFF) ? ovf_cnt_o : ovf_cnt_o + 16'd1;
        ovf_sticky_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_usr_regwr_evq.sv
// tb_usr_regwr_evq: directed and random stimulus checked against a queue-based event model
module tb_usr_regwr_evq;
  logic        usr_clk = 0, usr_rst = 1, run = 1, wr_en = 0, ready = 0, clr = 0;
  logic [19:0] addr = 0;
  logic [31:0] data = 0;
  logic        evt_valid, evq_full, ovf_sticky;
  logic [13:0] evt_addr;
  logic [31:0] evt_data;
  logic [4:0]  evq_level;
  logic [15:0] ovf_cnt;

  usr_regwr_evq dut (
    .usr_clk(usr_clk), .usr_rst(usr_rst), .usr_regrw_run_i(run),
    .wr_en_i(wr_en), .wr_addr_i(addr), .wr_data_i(data),
    .evt_valid_o(evt_valid), .evt_ready_i(ready), .evt_addr_o(evt_addr), .evt_data_o(evt_data),
    .evq_level_o(evq_level), .evq_full_o(evq_full),
    .ovf_cnt_o(ovf_cnt), .ovf_sticky_o(ovf_sticky), .clr_i(clr)
  );

  always #5 usr_clk = ~usr_clk;

  typedef struct { logic [13:0] a; logic [31:0] d; } ev_t;
  ev_t q[$];
  int  m_ovf = 0;
  bit  m_sticky = 0, m_run_d = 0;
  int  n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock: optionally compare outputs to the model, then advance the model across the edge
  task automatic step(input bit chk = 1);
    bit hit, pop, fall;
    ev_t e;
    #1;
    if (chk) begin
      check("valid", evt_valid, q.size() > 0);
      check("level", evq_level, q.size());
      check("full", evq_full, q.size() == 16);
      check("ovf_cnt", ovf_cnt, m_ovf);
      check("sticky", ovf_sticky, m_sticky);
      if (q.size() > 0) begin
        check("head_addr", evt_addr, q[0].a);
        check("head_data", evt_data, q[0].d);
      end
    end
    if (usr_rst) begin
      q.delete(); m_ovf = 0; m_sticky = 0; m_run_d = 0;
    end else begin
      hit  = wr_en && addr[19:16] == 4'h0 && addr[15:2] >= 2 && addr[15:2] <= 511;
      fall = !run && m_run_d;
      pop  = q.size() > 0 && ready;
      if (fall) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (hit) begin
          if (q.size() < 16) begin
            e.a = addr[15:2]; e.d = data; q.push_back(e);
          end else if (!clr) begin
            m_sticky = 1;
            if (m_ovf < 65535) m_ovf++;
          end
        end
      end
      if (clr) begin m_ovf = 0; m_sticky = 0; end
      m_run_d = run;
    end
    @(posedge usr_clk); #1;
  endtask

  task automatic wr(input logic [19:0] a, input logic [31:0] d, input bit chk = 1);
    wr_en = 1; addr = a; data = d;
    step(chk);
    wr_en = 0;
  endtask

  function automatic logic [19:0] rand_addr();
    logic [13:0] w;
    case ($urandom % 4)
      0, 1: w = 14'($urandom_range(2, 511));
      2:    w = 14'($urandom_range(0, 1));
      default: w = 14'($urandom_range(512, 16383));
    endcase
    return {(($urandom % 6) == 0) ? 4'($urandom) : 4'h0, w, 2'b00};
  endfunction

  initial begin
    repeat (2) @(posedge usr_clk);
    #1;
    step(0);
    usr_rst = 0;
    step(1);
    // single event with ready held high
    ready = 1;
    wr(20'h0000C, 32'hA5A5_0001);
    check("t1_valid", evt_valid, 1);
    check("t1_addr", evt_addr, 14'd3);
    check("t1_data", evt_data, 32'hA5A5_0001);
    step();
    check("t1_level", evq_level, 0);
    // filtered addresses
    wr(20'h00000, 1); wr(20'h00004, 2); wr(20'h1000C, 3); wr(20'h00804, 4);
    step();
    check("miss_level", evq_level, 0);
    // fill, overflow by one, drain in order
    ready = 0;
    for (int i = 0; i < 16; i++) wr(20'h00010 + 20'(4 * i), i);
    check("fill_full", evq_full, 1);
    check("fill_level", evq_level, 16);
    wr(20'h00100, 16);
    check("ovf_one", ovf_cnt, 1);
    check("ovf_sticky", ovf_sticky, 1);
    ready = 1;
    repeat (17) step();
    // full with simultaneous hit and pop
    clr = 1; step(); clr = 0;
    ready = 0;
    for (int i = 0; i < 16; i++) wr(20'h00020, 32'h100 + i);
    ready = 1;
    wr(20'h00024, 32'hDEAD_0099);
    check("fhp_level", evq_level, 16);
    check("fhp_ovf", ovf_cnt, 0);
    repeat (17) step();
    // flush on run-gate fall with a concurrent hit
    ready = 0;
    for (int i = 0; i < 5; i++) wr(20'h00040, 32'h200 + i);
    run = 0;
    wr(20'h00044, 32'h0BAD);
    check("flush_valid", evt_valid, 0);
    check("flush_level", evq_level, 0);
    check("flush_ovf", ovf_cnt, 0);
    wr(20'h00048, 32'h300);
    run = 1;
    ready = 1;
    repeat (2) step();
    // counter saturation and clear priority
    ready = 0;
    for (int i = 0; i < 16; i++) wr(20'h00050, i, 0);
    for (int i = 0; i < 65535; i++) wr(20'h00050, i, 0);
    step();
    check("sat_cnt", ovf_cnt, 16'hFFFF);
    wr(20'h00050, 7);
    check("sat_hold", ovf_cnt, 16'hFFFF);
    clr = 1;
    wr(20'h00050, 8);
    clr = 0;
    check("clr_cnt", ovf_cnt, 0);
    check("clr_sticky", ovf_sticky, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom % 3) != 0;
      addr    = rand_addr();
      data    = $urandom;
      ready   = ($urandom % 4) == 0;
      run     = ($urandom % 40) != 0;
      clr     = ($urandom % 100) == 0;
      usr_rst = ($urandom % 500) == 0;
      step();
    end
    usr_rst = 0; wr_en = 0; clr = 0; run = 1;
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
